// File: rtl/uart_frame_loader.sv
//------------------------------------------------------------------------------
// uart_frame_loader : 8N1 UART receiver that assembles a 9-row x 8-bit display
//                     frame behind a sync byte and commits it atomically.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_frame_loader #(
  parameter int          CLKS_PER_BIT = 234,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 2_700_000
) (
  input  logic        XTAL_IN,
  input  logic        ARST_N,
  input  logic        UART_RX,
  output logic [71:0] FRAME,
  output logic        FRAME_UPD,
  output logic        BYTE_VALID,
  output logic [7:0]  BYTE_DATA,
  output logic        FRAME_ERR
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            GW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic       {P_HUNT, P_LOAD}                 p_state_t;

  logic            rx_meta_q, rx_s_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            stop_err_q, stop_err_d;

  p_state_t        p_state_q, p_state_d;
  logic [3:0]      idx_q, idx_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [71:0]     frame_q, frame_d;
  logic            frame_upd_q, frame_upd_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge XTAL_IN or negedge ARST_N) begin
    if (!ARST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    stop_err_d   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          rx_state_d = R_START;
          bit_cnt_d  = 3'd0;
        end
      end
      R_START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = R_IDLE;
          if (rx_s_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            stop_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge XTAL_IN or negedge ARST_N) begin
    if (!ARST_N) begin
      rx_state_q   <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      stop_err_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      stop_err_q   <= stop_err_d;
    end
  end

  always_comb begin
    p_state_d   = p_state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    gap_d       = '0;
    frame_d     = frame_q;
    frame_upd_d = 1'b0;
    frame_err_d = 1'b0;
    case (p_state_q)
      P_HUNT: begin
        if (byte_valid_q && (byte_data_q == SYNC_BYTE)) begin
          p_state_d = P_LOAD;
          idx_d     = 4'd0;
        end
      end
      P_LOAD: begin
        gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
        // A byte arriving in the timeout cycle takes priority over the abort.
        if (byte_valid_q) begin
          gap_d = '0;
          if (idx_q == 4'd8) begin
            frame_d     = {byte_data_q, shadow_q};
            frame_upd_d = 1'b1;
            p_state_d   = P_HUNT;
            idx_d       = 4'd0;
          end else begin
            shadow_d[{idx_q[2:0], 3'b000} +: 8] = byte_data_q;
            idx_d = idx_q + 4'd1;
          end
        end else if (stop_err_q || (gap_q == GAP_MAX)) begin
          frame_err_d = 1'b1;
          p_state_d   = P_HUNT;
          idx_d       = 4'd0;
        end
      end
      default: p_state_d = P_HUNT;
    endcase
  end

  always_ff @(posedge XTAL_IN or negedge ARST_N) begin
    if (!ARST_N) begin
      p_state_q   <= P_HUNT;
      idx_q       <= 4'd0;
      shadow_q    <= 64'd0;
      gap_q       <= '0;
      frame_q     <= 72'd0;
      frame_upd_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      gap_q       <= gap_d;
      frame_q     <= frame_d;
      frame_upd_q <= frame_upd_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign FRAME      = frame_q;
  assign FRAME_UPD  = frame_upd_q;
  assign BYTE_VALID = byte_valid_q;
  assign BYTE_DATA  = byte_data_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
//------------------------------------------------------------------------------
// tb_uart_frame_loader : directed self-checking bench for uart_frame_loader.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_frame_loader;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic        clk    = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx     = 1'b1;
  logic [71:0] FRAME;
  logic        FRAME_UPD;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        FRAME_ERR;

  uart_frame_loader #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) u_dut (
    .XTAL_IN    (clk),
    .ARST_N     (arst_n),
    .UART_RX    (rx),
    .FRAME      (FRAME),
    .FRAME_UPD  (FRAME_UPD),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int bv_cnt = 0, upd_cnt = 0, ferr_cnt = 0, sneak_cnt = 0;
  logic [71:0] prev_frame = 72'd0;

  // Pulse counters, plus a count of FRAME changes not flagged by FRAME_UPD.
  always @(negedge clk) begin
    if (BYTE_VALID) bv_cnt   <= bv_cnt + 1;
    if (FRAME_UPD)  upd_cnt  <= upd_cnt + 1;
    if (FRAME_ERR)  ferr_cnt <= ferr_cnt + 1;
    if (arst_n && (FRAME != prev_frame) && !FRAME_UPD) sneak_cnt <= sneak_cnt + 1;
    prev_frame <= FRAME;
  end

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  logic [7:0] nom   [10] = '{8'hA5, 8'h00, 8'h18, 8'h24, 8'h42, 8'h81, 8'h81, 8'h42, 8'h24, 8'h18};
  logic [7:0] garb  [12] = '{8'h3C, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
  logic [7:0] recov [10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  localparam logic [71:0] F_NOM   = 72'h18_24_42_81_81_42_24_18_00;
  localparam logic [71:0] F_GARB  = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] F_RECOV = 72'h99_88_77_66_55_A5_33_22_11;

  int b0, u0, e0;

  initial begin
    idle(3);
    check_val("rst_frame",  FRAME, 72'd0);
    check_val("rst_pulses", {FRAME_UPD, BYTE_VALID, FRAME_ERR}, 72'd0);
    check_val("rst_data",   BYTE_DATA, 72'd0);
    arst_n = 1'b1;
    idle(10);

    b0 = bv_cnt; u0 = upd_cnt;
    foreach (nom[i]) send_byte(nom[i], 1'b1);
    idle(20);
    check_val("nom_bv",    bv_cnt - b0, 10);
    check_val("nom_upd",   upd_cnt - u0, 1);
    check_val("nom_frame", FRAME, F_NOM);
    check_val("nom_data",  BYTE_DATA, 8'h18);

    b0 = bv_cnt; u0 = upd_cnt;
    foreach (garb[i]) send_byte(garb[i], 1'b1);
    idle(20);
    check_val("garb_bv",    bv_cnt - b0, 12);
    check_val("garb_upd",   upd_cnt - u0, 1);
    check_val("garb_frame", FRAME, F_GARB);

    b0 = bv_cnt; u0 = upd_cnt; e0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(3 * CPB);
    check_val("ferr_pulse", ferr_cnt - e0, 1);
    check_val("ferr_bv",    bv_cnt - b0, 3);
    check_val("ferr_upd",   upd_cnt - u0, 0);
    check_val("ferr_frame", FRAME, F_GARB);
    u0 = upd_cnt;
    foreach (recov[i]) send_byte(recov[i], 1'b1);
    idle(20);
    check_val("recov_upd",   upd_cnt - u0, 1);
    check_val("recov_frame", FRAME, F_RECOV);
    check_val("recov_noerr", ferr_cnt - e0, 1);

    b0 = bv_cnt; u0 = upd_cnt; e0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(900);
    check_val("tmo_early", ferr_cnt - e0, 0);
    for (int i = 0; i < 400 && ferr_cnt == e0; i++) @(negedge clk);
    idle(2);
    check_val("tmo_pulse", ferr_cnt - e0, 1);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    idle(20);
    check_val("tmo_bv",    bv_cnt - b0, 11);
    check_val("tmo_upd",   upd_cnt - u0, 0);
    check_val("tmo_frame", FRAME, F_RECOV);
    check_val("tmo_hunt",  ferr_cnt - e0, 1);

    b0 = bv_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CPB);
    check_val("glitch_bv", bv_cnt - b0, 0);
    send_byte(8'h5A, 1'b1);
    idle(CPB);
    check_val("glitch_next_bv",   bv_cnt - b0, 1);
    check_val("glitch_next_data", BYTE_DATA, 8'h5A);

    fork
      send_byte(8'hC3, 1'b1);
      begin
        idle(40);
        #2 arst_n = 1'b0;
        #1;
        check_val("arst_frame",  FRAME, 72'd0);
        check_val("arst_pulses", {FRAME_UPD, BYTE_VALID, FRAME_ERR}, 72'd0);
        check_val("arst_data",   BYTE_DATA, 72'd0);
      end
    join
    arst_n = 1'b1;
    b0 = bv_cnt; u0 = upd_cnt; e0 = ferr_cnt;
    idle(20 * CPB);
    check_val("post_rst_pulses", (bv_cnt - b0) + (upd_cnt - u0) + (ferr_cnt - e0), 0);
    check_val("post_rst_frame",  FRAME, 72'd0);
    check_val("atomic_frame",    sneak_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
